ms_display_driver: RTL and testbench
====================================

Name: ms_display_driver

Overview:
- Downstream consumer of the millisecond stopwatch counter.
- Periodically samples the 20-bit binary ms count and converts it to decimal with a sequential double-dabble.
- Drives six active-low 7-segment displays (HEX5..HEX0) with registered outputs.
- Saturates at the maximum displayable value and flags overflow.

Parameters:
- WIDTH, 20, width of the binary input count.
- DIGITS, 6, number of decimal digits/displays; maximum shown value is 10^DIGITS-1.
- REFRESH_DIV, 50000, clk cycles between samples (1 ms at 50 MHz); must be >= WIDTH+3.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- ms_count  input  WIDTH  binary millisecond count from the stopwatch counter.
- hex0..hex5  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 is the least-significant digit.
- overflow  output  1  high when the last sample exceeded 10^DIGITS-1.
- conv_done  output  1  one-cycle pulse when the hex outputs update.

Behaviour:
- Interface: clock clk; reset reset_n, asynchronous, active-low.
- Reset values:
  - hex0..hex5 = 7'h7F (blank).
  - overflow = 0, conv_done = 0.
  - FSM = IDLE; refresh timer = 0; BCD/shift registers = 0.
- Refresh timer:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = terminal count; the timer runs freely in all states.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE, on tick: capture ms_count into the shift register.
    - If ms_count > 10^DIGITS-1, capture 10^DIGITS-1 and set the pending-overflow bit; otherwise clear it.
    - Clear the BCD accumulator, set the bit counter to WIDTH, go to SHIFT.
  - IDLE with no tick: hold.
  - SHIFT, one bit per cycle:
    - Every BCD nibble >= 5 gets +3.
    - Then shift {bcd, bin} left by 1 (all in the same cycle).
    - Decrement the bit counter; after the WIDTH-th shift go to LOAD.
  - LOAD: register the seg7 encodings of all DIGITS nibbles into hex*, copy pending-overflow to overflow, pulse conv_done high for exactly this cycle, go to IDLE.
- Latency: capture edge E0; shifts on E1..E_WIDTH; hex*, overflow and conv_done update on edge E_{WIDTH+1}. conv_done is high during the cycle following E_{WIDTH+1}.
- A tick while in SHIFT or LOAD is ignored. There is no queueing; the next conversion waits for the following tick.
- ms_count changes after capture do not affect the in-flight conversion.
- Leading zeros are displayed, e.g. 42 shows 000042.
- hex* hold their last value between updates; there is no glitching during SHIFT.
- BCD accumulator width is 4*DIGITS. The saturation guarantees no nibble exceeds 9 and no carry is lost.
- Reset asserted mid-conversion forces all reset values immediately. The timer restarts from 0, so the first tick comes REFRESH_DIV cycles after reset release.
- Segment encoding (active-low, gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Nibbles A..F never occur; they encode blank (7F).

Decomposition:
- Package ms_display_pkg:
  - State enum {IDLE, SHIFT, LOAD}.
  - SEG_BLANK = 7'h7F.
  - Segment constants for digits 0..9.
  - Function computing MAX_VAL = 10^DIGITS-1.
- Sub-module seg7_decoder: combinational 4-bit BCD to 7-bit active-low, instantiated DIGITS times (generate loop) and feeding the hex output registers.

Test Plan (REFRESH_DIV=32 in the bench):
- Reset, then hold 30 cycles -> hex0..hex5 = 7F, overflow = 0, conv_done never pulses.
- ms_count = 0, wait for the first tick -> conv_done pulses once exactly WIDTH+1 cycles after the capture edge; all hex = 40; overflow = 0.
- ms_count = 123456 -> hex5..hex0 = 79, 24, 30, 19, 12, 02; overflow = 0.
- ms_count = 1000000, then 20'hFFFFF -> all hex = 10 (999999) and overflow = 1 for both. Then ms_count = 7 -> hex0 = 78, others 40, overflow = 0.
- ms_count = 500 captured, changed to 999 during SHIFT -> display shows 000500; the next conversion shows 000999. A tick arriving during SHIFT is dropped (REFRESH_DIV forced small in a dedicated run: only one conv_done per completed conversion).
- Reset pulsed mid-SHIFT after displaying 123456 -> hex immediately 7F, overflow = 0, no conv_done. The next conversion occurs REFRESH_DIV cycles after release.

Source files
------------

// File: rtl/ms_display_pkg.sv
// Shared types and constants for the millisecond display driver:
// conversion FSM states, active-low 7-segment patterns and the
// saturation limit helper.
package ms_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Largest value representable on 'digits' decimal displays (10^digits - 1)
    function automatic longint unsigned max_val(input int digits);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/ms_display_driver_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles show blank.
module seg7_decoder
    import ms_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Lookup of the segment pattern for one decimal digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ms_display_driver.sv
// Samples the stopwatch millisecond count every REFRESH_DIV clocks,
// converts it to BCD with a bit-serial double-dabble and drives six
// active-low 7-segment displays. Values above 10^DIGITS-1 saturate
// and raise overflow.
module ms_display_driver
    import ms_display_pkg::*;
#(
    parameter int WIDTH       = 20,
    parameter int DIGITS      = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ms_count,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5,
    output logic             overflow,
    output logic             conv_done
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam longint unsigned MAX_VAL = max_val(DIGITS);

    logic [TW-1:0]       timer_q;
    logic                tick;
    state_e              state_q;
    logic [WIDTH-1:0]    bin_q;
    logic [BW-1:0]       bcd_q;
    logic [CW-1:0]       cnt_q;
    logic                ovf_pend_q;
    logic                overflow_q;
    logic                conv_done_q;
    logic [6:0]          hex_q [6];

    logic                over_range;
    logic [BW-1:0]       bcd_adj_d;
    logic [BW+WIDTH-1:0] shift_d;
    logic [6:0]          seg_w [6];

    assign tick       = (timer_q == TW'(REFRESH_DIV - 1));
    assign over_range = (64'(ms_count) > MAX_VAL);

    // Free-running refresh timer; terminal count is the sample tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // Add-3 correction on every BCD nibble that is 5 or more before shifting
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int n = 0; n < DIGITS; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj_d[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    assign shift_d = {bcd_adj_d, bin_q} << 1;

    // One decoder per digit; displays beyond DIGITS stay blank
    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
        if (gi < DIGITS) begin : g_dec
            seg7_decoder u_seg (
                .bcd_i (bcd_q[4*gi +: 4]),
                .seg_o (seg_w[gi])
            );
        end else begin : g_blank
            assign seg_w[gi] = SEG_BLANK;
        end
    end

    // Conversion FSM: capture on tick, WIDTH shift cycles, then load displays
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            conv_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (over_range) begin
                            bin_q      <= WIDTH'(MAX_VAL);
                            ovf_pend_q <= 1'b1;
                        end else begin
                            bin_q      <= ms_count;
                            ovf_pend_q <= 1'b0;
                        end
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= shift_d[BW+WIDTH-1:WIDTH];
                    bin_q <= shift_d[WIDTH-1:0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 6; i++) begin
                        hex_q[i] <= seg_w[i];
                    end
                    overflow_q  <= ovf_pend_q;
                    conv_done_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hex0      = hex_q[0];
    assign hex1      = hex_q[1];
    assign hex2      = hex_q[2];
    assign hex3      = hex_q[3];
    assign hex4      = hex_q[4];
    assign hex5      = hex_q[5];
    assign overflow  = overflow_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_ms_display_driver.sv
// Bench for ms_display_driver: directed and random millisecond counts
// compared against a decimal-arithmetic display model. A second
// instance with a very short refresh period exercises tick dropping.
module tb_ms_display_driver;

    localparam int WIDTH = 20;
    localparam int RD    = 32;
    localparam int RDF   = 8;
    localparam int MAXV  = 999999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] ms_count = '0;
    logic [19:0] ms_count_f = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  fhex0, fhex1, fhex2, fhex3, fhex4, fhex5;
    logic        overflow, conv_done, f_overflow, f_conv_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    ms_display_driver #(.WIDTH(WIDTH), .DIGITS(6), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset_n(reset_n), .ms_count(ms_count),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .overflow(overflow), .conv_done(conv_done)
    );

    ms_display_driver #(.WIDTH(WIDTH), .DIGITS(6), .REFRESH_DIV(RDF)) dut_f (
        .clk(clk), .reset_n(reset_n), .ms_count(ms_count_f),
        .hex0(fhex0), .hex1(fhex1), .hex2(fhex2), .hex3(fhex3), .hex4(fhex4), .hex5(fhex5),
        .overflow(f_overflow), .conv_done(f_conv_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: saturate, pick decimal digit d, look up its segment pattern
    function automatic logic [6:0] exp_seg(input int unsigned v, input int d);
        int unsigned s;
        s = (v > MAXV) ? MAXV : v;
        for (int k = 0; k < d; k++) s = s / 10;
        return seg_tab[s % 10];
    endfunction

    task automatic check_vals(input string tag, input logic [41:0] hv,
                              input logic ovf, input int unsigned v);
        for (int d = 0; d < 6; d++) begin
            check($sformatf("%s.hex%0d", tag, d), 32'(hv[7*d +: 7]), 32'(exp_seg(v, d)));
        end
        check({tag, ".ovf"}, 32'(ovf), (v > MAXV) ? 32'd1 : 32'd0);
    endtask

    task automatic check_disp(input string tag, input int unsigned v);
        check_vals(tag, {hex5, hex4, hex3, hex2, hex1, hex0}, overflow, v);
    endtask

    task automatic check_blank(input string tag);
        check({tag, ".hex"}, 32'({hex5, hex4, hex3, hex2, hex1, hex0}), 32'({6{7'h7F}}));
        check({tag, ".ovf"}, 32'(overflow), 32'd0);
        check({tag, ".done"}, 32'(conv_done), 32'd0);
    endtask

    // Bounded wait for conv_done; n = edges waited
    task automatic wait_conv(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!conv_done && n < 200);
        check({tag, ".seen"}, 32'(conv_done), 32'd1);
    endtask

    // Called one edge after a conv_done sample; next conversion uses v
    task automatic run_conv(input string tag, input int unsigned v);
        int n;
        ms_count = 20'(v);
        wait_conv(tag, n);
        check({tag, ".period"}, n, RD - 1);
        check_disp(tag, v);
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'(conv_done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        int first_edge;
        int last_edge;
        int fcount;
        int unsigned fv;
        int unsigned rv;
        int fperiod;

        // Reset and idle
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        reset_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (conv_done) pulses++;
        end
        check("idle.pulses", pulses, 0);
        check_blank("idle");

        // First conversion of zero: capture at edge RD, load WIDTH+1 later
        wait_conv("zero", n);
        check("zero.latency", 30 + n, RD + WIDTH + 1);
        check_disp("zero", 0);
        @(posedge clk); #1;
        check("zero.pulse", 32'(conv_done), 32'd0);

        // Directed values including saturation
        run_conv("d123456", 123456);
        run_conv("d1000000", 1000000);
        run_conv("dFFFFF", 20'hFFFFF);
        run_conv("d7", 7);

        // Random values, alternating full range and in-range
        for (int i = 0; i < 8; i++) begin
            rv = (i % 2 == 0) ? $urandom_range(20'hFFFFF, 0) : $urandom_range(MAXV, 0);
            run_conv($sformatf("rnd%0d", i), rv);
        end

        // Input change during SHIFT does not disturb the conversion
        ms_count = 20'd500;
        repeat (14) @(posedge clk);
        #1;
        ms_count = 20'd999;
        wait_conv("chg500", n);
        check("chg500.period", n + 14, RD - 1);
        check_disp("chg500", 500);
        @(posedge clk); #1;
        run_conv("chg999", 999);

        // Reset in the middle of a conversion
        run_conv("pre_rst", 123456);
        repeat (14) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_blank("mid_rst");
        @(posedge clk); #1;
        check_blank("mid_rst_hold");
        reset_n = 1'b1;
        wait_conv("post_rst", n);
        check("post_rst.latency", n, RD + WIDTH + 1);
        check_disp("post_rst", 123456);

        // Short refresh period: ticks during SHIFT/LOAD must be dropped
        fv = $urandom_range(MAXV, 0);
        ms_count_f = 20'(fv);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        fcount = 0;
        first_edge = -1;
        last_edge = -1;
        fperiod = RDF * ((WIDTH + 2 + RDF - 1) / RDF);
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (f_conv_done) begin
                fcount++;
                if (first_edge < 0) begin
                    first_edge = e;
                    check_vals("fast", {fhex5, fhex4, fhex3, fhex2, fhex1, fhex0}, f_overflow, fv);
                end else begin
                    check("fast.interval", e - last_edge, fperiod);
                end
                last_edge = e;
            end
        end
        check("fast.first", first_edge, RDF + WIDTH + 1);
        check("fast.count", fcount, (200 - (RDF + WIDTH + 1)) / fperiod + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
